// File: rtl/mcb_resp_pkg.sv
// Shared encodings and FSM state type for the MCB port responder.
package mcb_resp_pkg;

    localparam logic [2:0] INSTR_WR    = 3'b000;
    localparam logic [2:0] INSTR_RD    = 3'b001;
    localparam logic [2:0] INSTR_WR_AP = 3'b010;
    localparam logic [2:0] INSTR_RD_AP = 3'b011;
    localparam logic [2:0] INSTR_REF   = 3'b100;

    typedef enum logic [2:0] {
        CALIB      = 3'd0,
        IDLE       = 3'd1,
        WRITE      = 3'd2,
        READ       = 3'd3,
        READ_DRAIN = 3'd4
    } state_t;

    // Where IDLE goes after popping a command; refresh and unknown codes are dropped.
    function automatic state_t next_state_for(input logic [2:0] instr);
        case (instr)
            INSTR_WR, INSTR_WR_AP: next_state_for = WRITE;
            INSTR_RD, INSTR_RD_AP: next_state_for = READ;
            INSTR_REF:             next_state_for = IDLE;
            default:               next_state_for = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mcb_port_responder_fifo.sv
// Synchronous first-word-fall-through FIFO with registered count/full/empty.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int LOG2  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LOG2:0]    count
);
    localparam int DEPTH = 1 << LOG2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LOG2-1:0]  wr_ptr;
    logic [LOG2-1:0]  rd_ptr;
    logic [LOG2:0]    count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Occupancy after this cycle's accepted push/pop.
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (!do_push && do_pop)
            count_nxt = count - 1'b1;
    end

    // Pointers and registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (LOG2+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage is data only and never reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Head word falls through; forced to zero while empty so reset reads as 0.
    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mcb_port_responder.sv
// Block-RAM backed stand-in for one Spartan-6 MCB native user port.
module mcb_port_responder
    import mcb_resp_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int MEM_LOG2     = 10,
    parameter int FIFO_LOG2    = 6,
    parameter int CMD_LOG2     = 2,
    parameter int CALIB_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  calib_done,
    input  logic                  cmd_en,
    input  logic [2:0]            cmd_instr,
    input  logic [5:0]            cmd_bl,
    input  logic [29:0]           cmd_byte_addr,
    output logic                  cmd_full,
    output logic                  cmd_empty,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_mask,
    output logic                  wr_full,
    output logic                  wr_empty,
    output logic [FIFO_LOG2:0]    wr_count,
    output logic                  wr_underrun,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_full,
    output logic                  rd_empty,
    output logic [FIFO_LOG2:0]    rd_count
);
    localparam int MASK_W = DATA_W / 8;
    localparam int MEM_D  = 1 << MEM_LOG2;
    localparam int CMD_W  = 3 + 6 + MEM_LOG2;
    localparam int WRQ_W  = DATA_W + MASK_W;
    localparam int CAL_W  = $clog2(CALIB_CYCLES + 1);

    state_t                state;
    logic [CAL_W-1:0]      cal_cnt;
    logic [MEM_LOG2-1:0]   addr;
    logic [6:0]            remaining;

    logic [CMD_W-1:0]      cmd_q;
    logic [CMD_LOG2:0]     cmd_count;
    logic                  cmd_pop;
    logic [2:0]            cmd_q_instr;
    logic [5:0]            cmd_q_bl;
    logic [MEM_LOG2-1:0]   cmd_q_addr;

    logic [WRQ_W-1:0]      wr_q;
    logic [DATA_W-1:0]     wr_q_data;
    logic [MASK_W-1:0]     wr_q_mask;
    logic                  wr_pop;

    logic                  rd_issue;
    logic                  rd_pop;
    logic [FIFO_LOG2+1:0]  rd_level;
    logic [DATA_W-1:0]     mem_rd_p1;
    logic                  vld_p1;

    logic [DATA_W-1:0]     mem [MEM_D];

    logic                  unused_bits;
    assign unused_bits = ^{cmd_byte_addr[29:MEM_LOG2+3], cmd_byte_addr[2:0], cmd_count};

    sync_fifo_fwft #(.WIDTH(CMD_W), .LOG2(CMD_LOG2)) u_cmd_fifo (
        .clk(clk), .reset_n(reset_n),
        .push(cmd_en && calib_done),
        .din({cmd_instr, cmd_bl, cmd_byte_addr[MEM_LOG2+2:3]}),
        .pop(cmd_pop), .dout(cmd_q),
        .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
    );

    sync_fifo_fwft #(.WIDTH(WRQ_W), .LOG2(FIFO_LOG2)) u_wr_fifo (
        .clk(clk), .reset_n(reset_n),
        .push(wr_en && calib_done),
        .din({wr_mask, wr_data}),
        .pop(wr_pop), .dout(wr_q),
        .full(wr_full), .empty(wr_empty), .count(wr_count)
    );

    sync_fifo_fwft #(.WIDTH(DATA_W), .LOG2(FIFO_LOG2)) u_rd_fifo (
        .clk(clk), .reset_n(reset_n),
        .push(vld_p1), .din(mem_rd_p1),
        .pop(rd_en), .dout(rd_data),
        .full(rd_full), .empty(rd_empty), .count(rd_count)
    );

    assign {cmd_q_instr, cmd_q_bl, cmd_q_addr} = cmd_q;
    assign {wr_q_mask, wr_q_data}              = wr_q;

    assign cmd_pop = (state == IDLE) && !cmd_empty;
    assign wr_pop  = (state == WRITE) && !wr_empty;
    assign rd_pop  = rd_en && !rd_empty;

    // A read may be issued only if the word already in flight still leaves a free slot.
    assign rd_level = {1'b0, rd_count} + {{(FIFO_LOG2+1){1'b0}}, vld_p1}
                      - {{(FIFO_LOG2+1){1'b0}}, rd_pop};
    assign rd_issue = (state == READ) && (rd_level < (FIFO_LOG2+2)'(1 << FIFO_LOG2));

    // Port FSM: calibration wait, command dispatch, burst address/length tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= CALIB;
            cal_cnt     <= '0;
            calib_done  <= 1'b0;
            addr        <= '0;
            remaining   <= '0;
            wr_underrun <= 1'b0;
            vld_p1      <= 1'b0;
        end else begin
            vld_p1 <= rd_issue;
            case (state)
                CALIB: begin
                    if (cal_cnt == CAL_W'(CALIB_CYCLES - 1)) begin
                        calib_done <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cal_cnt <= cal_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (!cmd_empty) begin
                        addr      <= cmd_q_addr;
                        remaining <= {1'b0, cmd_q_bl} + 7'd1;
                        state     <= next_state_for(cmd_q_instr);
                    end
                end
                WRITE: begin
                    if (!wr_empty) begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == 7'd1) state <= IDLE;
                    end else begin
                        wr_underrun <= 1'b1;
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == 7'd1) state <= READ_DRAIN;
                    end
                end
                READ_DRAIN: state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end

    // p0 -> p1: byte-masked RAM write and registered RAM read share the burst address.
    always_ff @(posedge clk) begin
        if (wr_pop) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!wr_q_mask[b]) mem[addr][b*8 +: 8] <= wr_q_data[b*8 +: 8];
            end
        end
        if (rd_issue) mem_rd_p1 <= mem[addr];
    end

endmodule

// File: tb/tb_mcb_port_responder.sv
// Self-checking bench for mcb_port_responder: reference memory plus expected-read queue.
module tb_mcb_port_responder;
    localparam int DATA_W       = 64;
    localparam int MEM_LOG2     = 10;
    localparam int FIFO_LOG2    = 4;
    localparam int CMD_LOG2     = 2;
    localparam int CALIB_CYCLES = 16;
    localparam int MEM_D        = 1 << MEM_LOG2;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic                 calib_done;
    logic                 cmd_en = 1'b0;
    logic [2:0]           cmd_instr = '0;
    logic [5:0]           cmd_bl = '0;
    logic [29:0]          cmd_byte_addr = '0;
    logic                 cmd_full, cmd_empty;
    logic                 wr_en = 1'b0;
    logic [DATA_W-1:0]    wr_data = '0;
    logic [DATA_W/8-1:0]  wr_mask = '0;
    logic                 wr_full, wr_empty;
    logic [FIFO_LOG2:0]   wr_count;
    logic                 wr_underrun;
    logic                 rd_en = 1'b0;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_full, rd_empty;
    logic [FIFO_LOG2:0]   rd_count;

    int checks = 0;
    int errors = 0;

    logic [63:0] model_mem [MEM_D];
    logic [63:0] exp_q [$];

    mcb_port_responder #(
        .DATA_W(DATA_W), .MEM_LOG2(MEM_LOG2), .FIFO_LOG2(FIFO_LOG2),
        .CMD_LOG2(CMD_LOG2), .CALIB_CYCLES(CALIB_CYCLES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .calib_done(calib_done),
        .cmd_en(cmd_en), .cmd_instr(cmd_instr), .cmd_bl(cmd_bl),
        .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full), .cmd_empty(cmd_empty),
        .wr_en(wr_en), .wr_data(wr_data), .wr_mask(wr_mask),
        .wr_full(wr_full), .wr_empty(wr_empty), .wr_count(wr_count),
        .wr_underrun(wr_underrun), .rd_en(rd_en), .rd_data(rd_data),
        .rd_full(rd_full), .rd_empty(rd_empty), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All drivers and samplers work on the falling edge.
    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_wr(input logic [63:0] d, input logic [7:0] m);
        wr_en = 1'b1; wr_data = d; wr_mask = m;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] instr, input int bl, input int word);
        cmd_en = 1'b1; cmd_instr = instr; cmd_bl = 6'(bl);
        cmd_byte_addr = 30'(word * 8) | 30'd5;  // low byte-address bits must be ignored
        @(negedge clk);
        cmd_en = 1'b0;
    endtask

    task automatic model_wr(input int a, input logic [63:0] d, input logic [7:0] m);
        for (int b = 0; b < 8; b++)
            if (!m[b]) model_mem[a % MEM_D][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic expect_read(input int a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(model_mem[(a + i) % MEM_D]);
    endtask

    task automatic write_burst(input int a, input int n, input logic [63:0] base);
        logic [63:0] d;
        for (int i = 0; i < n; i++) begin
            d = base + 64'(i);
            push_wr(d, 8'h00);
            model_wr(a + i, d, 8'h00);
        end
        send_cmd(3'b000, n - 1, a);
        idle_cycles(n + 4);
    endtask

    // Pops the read FIFO and compares each word against the scoreboard head.
    task automatic drain(input string name, input int budget);
        logic [63:0] exp;
        int cyc = 0;
        while (exp_q.size() > 0 && cyc < budget) begin
            if (!rd_empty) begin
                exp = exp_q.pop_front();
                checks++;
                if (rd_data !== exp) begin
                    errors++;
                    $display("FAIL %s: rd_data=%h expected %h", name, rd_data, exp);
                end
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        rd_en = 1'b0;
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: %0d words missing, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        idle_cycles(5);
        checks++; if (calib_done !== 1'b0) begin errors++; $display("FAIL rst_calib: got %b expected 0", calib_done); end
        checks++; if (cmd_empty !== 1'b1) begin errors++; $display("FAIL rst_cmd_empty: got %b expected 1", cmd_empty); end
        checks++; if (cmd_full !== 1'b0) begin errors++; $display("FAIL rst_cmd_full: got %b expected 0", cmd_full); end
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL rst_rd_empty: got %b expected 1", rd_empty); end
        checks++; if (wr_count !== '0) begin errors++; $display("FAIL rst_wr_count: got %0d expected 0", wr_count); end
        checks++; if (wr_empty !== 1'b1) begin errors++; $display("FAIL rst_wr_empty: got %b expected 1", wr_empty); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL rst_rd_data: got %h expected 0", rd_data); end
        checks++; if (wr_underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b expected 0", wr_underrun); end
        reset_n = 1'b1;
        for (int k = 1; k <= CALIB_CYCLES; k++) begin
            wr_en = (k == 3); cmd_en = (k == 3); cmd_instr = 3'b001;
            @(negedge clk);
            checks++;
            if (calib_done !== (k == CALIB_CYCLES)) begin
                errors++;
                $display("FAIL calib_edge_%0d: got %b expected %b", k, calib_done, k == CALIB_CYCLES);
            end
        end
        wr_en = 1'b0; cmd_en = 1'b0;
        checks++; if (wr_count !== '0) begin errors++; $display("FAIL calib_wr_ignored: wr_count=%0d expected 0", wr_count); end
        checks++; if (cmd_empty !== 1'b1) begin errors++; $display("FAIL calib_cmd_ignored: cmd_empty=%b expected 1", cmd_empty); end
    endtask

    task automatic test_write_read;
        int lat;
        push_wr(64'd9, 8'h00); model_wr(16, 64'd9, 8'h00);
        push_wr(64'd8, 8'h00); model_wr(17, 64'd8, 8'h00);
        send_cmd(3'b000, 1, 16);
        idle_cycles(6);
        exp_q.push_back(64'd9);
        exp_q.push_back(64'd8);
        cmd_en = 1'b1; cmd_instr = 3'b001; cmd_bl = 6'd1; cmd_byte_addr = 30'd128;
        @(negedge clk);
        cmd_en = 1'b0;
        lat = 1;
        while (rd_empty && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency: got %0d cycles expected 4", lat); end
        @(negedge clk);
        checks++; if (rd_count !== 5'd2) begin errors++; $display("FAIL rd_count_two: got %0d expected 2", rd_count); end
        drain("write_read", 20);
    endtask

    task automatic test_masked_write;
        push_wr(64'h1111_1111_1111_1111, 8'h00); model_wr(0, 64'h1111_1111_1111_1111, 8'h00);
        send_cmd(3'b010, 0, 0);
        push_wr(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F); model_wr(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        send_cmd(3'b000, 0, 0);
        idle_cycles(6);
        exp_q.push_back(64'hFFFF_FFFF_1111_1111);
        send_cmd(3'b011, 0, 0);
        drain("masked_write", 20);
    endtask

    task automatic test_wrap;
        write_burst(MEM_D - 2, 4, 64'hC0DE_0000_0000_00A0);
        exp_q.push_back(64'hC0DE_0000_0000_00A2);
        exp_q.push_back(64'hC0DE_0000_0000_00A3);
        send_cmd(3'b001, 1, 0);
        drain("wrap_low", 20);
        expect_read(MEM_D - 2, 2);
        send_cmd(3'b001, 1, MEM_D - 2);
        drain("wrap_high", 20);
    endtask

    task automatic test_backpressure;
        int max_cnt = 0;
        for (int c = 0; c < 4; c++)
            write_burst(64 + c * 16, 16, 64'hA500_0000_0000_0000 + 64'(c * 256));
        send_cmd(3'b001, 63, 64);
        repeat (100) begin
            @(negedge clk);
            if (int'(rd_count) > max_cnt) max_cnt = int'(rd_count);
        end
        checks++; if (max_cnt !== 16) begin errors++; $display("FAIL bp_max_count: got %0d expected 16", max_cnt); end
        checks++; if (rd_count !== 5'd16) begin errors++; $display("FAIL bp_count: got %0d expected 16", rd_count); end
        checks++; if (rd_full !== 1'b1) begin errors++; $display("FAIL bp_full: got %b expected 1", rd_full); end
        expect_read(64, 64);
        drain("backpressure", 300);
    endtask

    task automatic test_underrun;
        checks++; if (wr_underrun !== 1'b0) begin errors++; $display("FAIL underrun_pre: got %b expected 0", wr_underrun); end
        push_wr(64'h5555_0000_0000_0001, 8'h00); model_wr(200, 64'h5555_0000_0000_0001, 8'h00);
        push_wr(64'h5555_0000_0000_0002, 8'h00); model_wr(201, 64'h5555_0000_0000_0002, 8'h00);
        send_cmd(3'b000, 3, 200);
        idle_cycles(10);
        checks++; if (wr_underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b expected 1", wr_underrun); end
        send_cmd(3'b001, 3, 200);
        idle_cycles(10);
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL underrun_blocks_read: rd_empty=%b expected 1", rd_empty); end
        push_wr(64'h5555_0000_0000_0003, 8'h00); model_wr(202, 64'h5555_0000_0000_0003, 8'h00);
        push_wr(64'h5555_0000_0000_0004, 8'h00); model_wr(203, 64'h5555_0000_0000_0004, 8'h00);
        expect_read(200, 4);
        drain("underrun_read", 50);
        checks++; if (wr_underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky: got %b expected 1", wr_underrun); end
    endtask

    task automatic test_reset_mid_burst;
        send_cmd(3'b001, 63, 64);
        idle_cycles(6);
        reset_n = 1'b0;
        idle_cycles(2);
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL mid_rd_empty: got %b expected 1", rd_empty); end
        checks++; if (rd_count !== '0) begin errors++; $display("FAIL mid_rd_count: got %0d expected 0", rd_count); end
        checks++; if (calib_done !== 1'b0) begin errors++; $display("FAIL mid_calib: got %b expected 0", calib_done); end
        checks++; if (wr_underrun !== 1'b0) begin errors++; $display("FAIL mid_underrun: got %b expected 0", wr_underrun); end
        reset_n = 1'b1;
        idle_cycles(CALIB_CYCLES + 4);
        checks++; if (calib_done !== 1'b1) begin errors++; $display("FAIL recal_done: got %b expected 1", calib_done); end
        checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL recal_rd_empty: got %b expected 1", rd_empty); end
        expect_read(200, 4);
        send_cmd(3'b001, 3, 200);
        drain("after_reset", 30);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_masked_write();
        test_wrap();
        test_backpressure();
        test_underrun();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcb_port_responder.md
# mcb_port_responder

Behavioural responder for one Spartan-6 MCB native user port, backed by on-chip block RAM instead of DDR2. It accepts the same command, write-FIFO and read-FIFO traffic that our DDR test and streaming blocks issue, and services it with simple fixed timing. This lets those initiators run in simulation, and on boards without DDR, with no MCB core.

## Interface
- `DATA_W`, 64: user data width; mask width is `DATA_W/8`.
- `MEM_LOG2`, 10: log2 of memory depth in `DATA_W` words.
- `FIFO_LOG2`, 6: log2 of write/read FIFO depth.
- `CMD_LOG2`, 2: log2 of command FIFO depth.
- `CALIB_CYCLES`, 16: cycles from reset release to `calib_done`.

Ports:
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `calib_done` out 1: port usable; reset 0.
- `cmd_en` in 1: push {`cmd_instr`, `cmd_bl`, `cmd_byte_addr`}.
- `cmd_instr` in 3: 000 write, 001 read, 010 write+AP, 011 read+AP, 100 refresh; others ignored.
- `cmd_bl` in 6: burst length minus 1 (1..64 words).
- `cmd_byte_addr` in 30: byte address; bits [2:0] ignored.
- `cmd_full`, `cmd_empty` out 1 each: command FIFO status; reset 0 / 1.
- `wr_en` in 1: push `wr_data`/`wr_mask`.
- `wr_data` in DATA_W, `wr_mask` in DATA_W/8: mask bit 1 means that byte is not written.
- `wr_full`, `wr_empty` out 1; `wr_count` out FIFO_LOG2+1: reset 0 / 1 / 0.
- `wr_underrun` out 1: sticky; set when a write burst starves; reset 0.
- `rd_en` in 1: pop the read FIFO.
- `rd_data` out DATA_W: first-word-fall-through; valid when `rd_empty`=0; reset 0.
- `rd_full`, `rd_empty` out 1; `rd_count` out FIFO_LOG2+1: reset 0 / 1 / 0.

## Operation
- **CALIB**: counts `CALIB_CYCLES`, sets `calib_done`, then goes to IDLE. While `calib_done`=0, `cmd_en` and `wr_en` are ignored.
- **IDLE**: if the command FIFO is not empty, pop one entry.
  - Latch word address = `cmd_byte_addr[MEM_LOG2+2:3]` and remaining = `cmd_bl`+1.
  - Next state: WRITE for 000/010, READ for 001/011.
  - Refresh or an undefined instruction: pop and discard, stay in IDLE.
- **WRITE**: each cycle the write FIFO is not empty, pop one word and write the unmasked bytes.
  - Increment the address modulo 2^MEM_LOG2 and decrement remaining.
  - Write FIFO empty with remaining>0: stall and set `wr_underrun`.
  - remaining reaches 0: go to IDLE.
- **READ**: each cycle `rd_full`=0, issue a memory read, increment the address (wrapping) and decrement remaining.
  - Memory data is pushed into the read FIFO one cycle later.
  - Read FIFO full: issue nothing that cycle; no data is lost.
  - After the last issue, wait one cycle for its push, then go to IDLE.
- Commands execute strictly in order; data of one burst is never interleaved with another.
- Push to a full FIFO is ignored. Pop from an empty FIFO is ignored. Simultaneous push and pop leave the count unchanged.
- Reset, including mid-burst:
  - All FIFOs are emptied, `wr_underrun` clears, `calib_done` drops and CALIB restarts.
  - Memory contents are not cleared.

## Timing
- `calib_done` rises `CALIB_CYCLES` cycles after the first `clk` edge with `reset_n`=1.
- FIFO status (`*_full`, `*_empty`, `*_count`) is registered and reflects a push or pop on the following cycle.
- Write command `cmd_en` at cycle N with data already queued:
  - Command popped at N+1.
  - First memory write at N+2.
  - One word per cycle thereafter.
- Read command `cmd_en` at cycle N:
  - First memory read issued at N+2.
  - `rd_empty` falls at N+4.
  - Then one word per cycle while not full.
- Throughput is 1 word/clk sustained in both directions. There is no refresh or turnaround penalty.

## Structure
- Package `mcb_resp_pkg` holds:
  - instruction encodings (`INSTR_WR`, `INSTR_RD`, `INSTR_WR_AP`, `INSTR_RD_AP`, `INSTR_REF`);
  - the state enum (CALIB, IDLE, WRITE, READ, READ_DRAIN).
- Sub-module `sync_fifo_fwft`:
  - parameterised width/depth, registered count/full/empty, first-word-fall-through output;
  - instantiated three times (command, write, read).
- Memory is an inferred simple dual-port RAM with byte enables, inside the top module.

## Test plan
- **Reset/calibration**: hold `reset_n`=0 for 5 cycles, release -> `calib_done`=0 for 16 cycles then 1; `cmd_empty`=1, `rd_empty`=1, `wr_count`=0.
- **Write then read**:
  - Write words 9, 8; write cmd bl=1 at addr 16; read cmd bl=1 at addr 16.
  - -> `rd_empty` falls 4 cycles after the read `cmd_en`.
  - -> `rd_data`=9, then 8 after one `rd_en`.
- **Masked write**:
  - Fill addr 0 with 0x1111_1111_1111_1111.
  - Write 0xFFFF_FFFF_FFFF_FFFF with mask 0x0F.
  - -> read returns 0xFFFF_FFFF_1111_1111.
- **Wrap-around**:
  - Write bl=3 at the byte address of word 2^MEM_LOG2−2.
  - -> read from word 0 returns the 3rd and 4th words written.
- **Back-pressure and underrun**:
  - Read bl=63 with no `rd_en` and FIFO_LOG2=4 -> `rd_count` stops at 16 with no loss; drain and get all 64 words in order.
  - Write bl=3 with only 2 words queued -> `wr_underrun`=1 and the FSM stays in WRITE until 2 more words arrive.
- **Reset mid-burst**:
  - Assert `reset_n`=0 during a READ -> `rd_empty`=1, `calib_done`=0.
  - After recalibration, a fresh read returns data written before the reset.
